// File: rtl/rv32i_if_stage.sv
// RV32I instruction-fetch stage.
// Issues one instruction-memory request at a time, parks a response in a
// skid register while decode is stalled, discards responses that belong to
// a redirected path, and presents the fetched word to decode through IF/ID.
module rv32i_if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic        if_id_valid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HELD = 2'd3
    } state_t;

    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ALIGN_MASK;

    state_t      state;
    logic [31:0] pc;
    logic        req_q;
    logic        kill;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc;

    logic [31:0] redirect_target;
    logic [31:0] pc_plus4;
    logic        load_fresh;
    logic        load_skid;

    assign redirect_target = redirect_pc & ALIGN_MASK;
    // Wraps naturally at 2^32 because the sum is truncated to 32 bits.
    assign pc_plus4        = pc + 32'd4;
    assign imem_req        = req_q;
    assign imem_addr       = pc & ALIGN_MASK;

    // Decide whether IF/ID takes a new instruction this cycle.
    // NOTE: every signal driven in always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        load_fresh = 1'b0;
        load_skid  = 1'b0;
        if (state == WAIT && imem_rvalid && !kill && !redirect_valid && !stall)
            load_fresh = 1'b1;
        if (state == HELD && !redirect_valid && !stall)
            load_skid = 1'b1;
    end

    // Fetch FSM: owns pc, the request strobe, the kill flag and the skid entry.
    // NOTE: all state is updated with non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC_ALIGNED;
            req_q      <= 1'b0;
            kill       <= 1'b0;
            skid_instr <= 32'd0;
            skid_pc    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    // Any response seen here belongs to a pre-reset request.
                    if (redirect_valid)
                        pc <= redirect_target;
                    state <= REQ;
                    req_q <= 1'b1;
                end

                REQ: begin
                    if (redirect_valid) begin
                        pc <= redirect_target;
                        if (imem_gnt) begin
                            // Old address was accepted: its response must be dropped.
                            state <= WAIT;
                            req_q <= 1'b0;
                            kill  <= 1'b1;
                        end
                    end else if (imem_gnt) begin
                        state <= WAIT;
                        req_q <= 1'b0;
                    end
                end

                WAIT: begin
                    if (imem_rvalid) begin
                        if (kill || redirect_valid) begin
                            // Response is from an abandoned path.
                            kill  <= 1'b0;
                            state <= REQ;
                            req_q <= 1'b1;
                            if (redirect_valid)
                                pc <= redirect_target;
                        end else if (stall) begin
                            skid_instr <= imem_rdata;
                            skid_pc    <= pc;
                            state      <= HELD;
                        end else begin
                            pc    <= pc_plus4;
                            state <= REQ;
                            req_q <= 1'b1;
                        end
                    end else if (redirect_valid) begin
                        pc   <= redirect_target;
                        kill <= 1'b1;
                    end
                end

                HELD: begin
                    if (redirect_valid) begin
                        // Leaving HELD abandons the parked word.
                        pc         <= redirect_target;
                        skid_instr <= 32'd0;
                        skid_pc    <= 32'd0;
                        state      <= REQ;
                        req_q      <= 1'b1;
                    end else if (!stall) begin
                        pc    <= pc_plus4;
                        state <= REQ;
                        req_q <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

    // IF/ID register: bubble on flush/redirect, hold on stall, otherwise
    // take a new word or present a bubble so decode sees each word once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id_instr <= NOP_INSTR;
            if_id_pc    <= 32'd0;
            if_id_valid <= 1'b0;
        end else if (flush || redirect_valid) begin
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
        end else if (load_fresh) begin
            if_id_instr <= imem_rdata;
            if_id_pc    <= pc;
            if_id_valid <= 1'b1;
        end else if (load_skid) begin
            if_id_instr <= skid_instr;
            if_id_pc    <= skid_pc;
            if_id_valid <= 1'b1;
        end else if (!stall) begin
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rv32i_if_stage.sv
// Self-checking bench for rv32i_if_stage: a directed cycle table, a reset
// sequence in the middle of a fetch, and a randomized run scored against a
// transaction-level model of the fetch stream.
module tb_rv32i_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush, redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt, imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_instr, if_id_pc;
    logic        if_id_valid;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    rv32i_if_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_valid    (if_id_valid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    // Contents of the imaginary instruction memory.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = a & 32'hFFFF_FFFC;
        return {w[15:0], w[31:16]} ^ 32'hA5C3_0F1B ^ w;
    endfunction

    typedef struct {
        logic        stall, flush, redir;
        logic [31:0] redir_pc;
        logic        gnt, rvalid;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr, e_pc;
    } vec_t;

    function automatic vec_t mk(input logic s, f, r, input logic [31:0] rp,
                                input logic g, v, input logic [31:0] rd,
                                input logic er, input logic [31:0] ea,
                                input logic ev, input logic [31:0] ei, ep);
        vec_t t;
        t.stall = s; t.flush = f; t.redir = r; t.redir_pc = rp;
        t.gnt = g; t.rvalid = v; t.rdata = rd;
        t.e_req = er; t.e_addr = ea; t.e_valid = ev; t.e_instr = ei; t.e_pc = ep;
        return t;
    endfunction

    task automatic drive_idle();
        stall = 0; flush = 0; redirect_valid = 0; redirect_pc = 0;
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = $urandom;
    endtask

    // Transaction-level model state for the random run.
    logic        m_valid;
    logic [31:0] m_instr, m_pc, m_next;
    logic        pend, pend_kill, rdy;
    logic [31:0] pend_addr, rdy_addr;
    logic        mem_busy;
    int          mem_wait;
    logic [31:0] mem_addr;
    int          quiet;

    initial begin
        vec_t tbl[19];

        // Columns: stall flush redir redir_pc gnt rvalid rdata | req addr valid instr pc
        tbl[0]  = mk(0,0,0,0,            0,0,0,            0,32'h0,       0,NOP,          32'h0);
        tbl[1]  = mk(0,0,0,0,            1,0,0,            1,32'h0,       0,NOP,          32'h0);
        tbl[2]  = mk(0,0,0,0,            0,1,32'h0050_0093,0,32'h0,       0,NOP,          32'h0);
        tbl[3]  = mk(1,0,0,0,            1,0,0,            1,32'h4,       1,32'h0050_0093,32'h0);
        tbl[4]  = mk(1,0,0,0,            0,1,32'h00A0_0113,0,32'h4,       1,32'h0050_0093,32'h0);
        tbl[5]  = mk(1,0,0,0,            0,0,0,            0,32'h4,       1,32'h0050_0093,32'h0);
        tbl[6]  = mk(1,0,0,0,            0,0,0,            0,32'h4,       1,32'h0050_0093,32'h0);
        tbl[7]  = mk(0,0,0,0,            0,0,0,            0,32'h4,       1,32'h0050_0093,32'h0);
        tbl[8]  = mk(0,0,0,0,            1,0,0,            1,32'h8,       1,32'h00A0_0113,32'h4);
        tbl[9]  = mk(0,0,1,32'h103,      0,0,0,            0,32'h8,       0,NOP,          32'h4);
        tbl[10] = mk(0,0,0,0,            0,1,32'hDEAD_BEEF,0,32'h100,     0,NOP,          32'h4);
        tbl[11] = mk(0,0,0,0,            1,0,0,            1,32'h100,     0,NOP,          32'h4);
        tbl[12] = mk(0,0,0,0,            0,1,32'h0010_8093,0,32'h100,     0,NOP,          32'h4);
        tbl[13] = mk(1,1,0,0,            0,0,0,            1,32'h104,     1,32'h0010_8093,32'h100);
        tbl[14] = mk(0,0,1,32'hFFFF_FFFC,0,0,0,            1,32'h104,     0,NOP,          32'h100);
        tbl[15] = mk(0,0,0,0,            1,0,0,            1,32'hFFFF_FFFC,0,NOP,         32'h100);
        tbl[16] = mk(0,0,0,0,            0,1,32'h0000_0073,0,32'hFFFF_FFFC,0,NOP,         32'h100);
        tbl[17] = mk(0,0,0,0,            0,0,0,            1,32'h0,       1,32'h0000_0073,32'hFFFF_FFFC);
        tbl[18] = mk(0,0,0,0,            1,0,0,            1,32'h0,       0,NOP,          32'hFFFF_FFFC);

        rst_n = 0;
        drive_idle();
        repeat (2) @(negedge clk);
        rst_n = 1;

        // Directed table: outputs of each cycle, inputs for its closing edge.
        for (int i = 0; i < 19; i++) begin
            stall = tbl[i].stall; flush = tbl[i].flush;
            redirect_valid = tbl[i].redir; redirect_pc = tbl[i].redir_pc;
            imem_gnt = tbl[i].gnt; imem_rvalid = tbl[i].rvalid;
            imem_rdata = tbl[i].rvalid ? tbl[i].rdata : $urandom;
            check($sformatf("row%0d imem_req", i),    {31'd0, imem_req},    {31'd0, tbl[i].e_req});
            check($sformatf("row%0d imem_addr", i),   imem_addr,            tbl[i].e_addr);
            check($sformatf("row%0d if_id_valid", i), {31'd0, if_id_valid}, {31'd0, tbl[i].e_valid});
            check($sformatf("row%0d if_id_instr", i), if_id_instr,          tbl[i].e_instr);
            check($sformatf("row%0d if_id_pc", i),    if_id_pc,             tbl[i].e_pc);
            @(negedge clk);
        end

        // Last row granted address 0, so the stage now waits for data.
        // Reset asynchronously in the middle of that wait.
        drive_idle();
        #2 rst_n = 0;
        #1;
        check("async_rst imem_req",    {31'd0, imem_req},    32'd0);
        check("async_rst imem_addr",   imem_addr,            32'd0);
        check("async_rst if_id_valid", {31'd0, if_id_valid}, 32'd0);
        check("async_rst if_id_instr", if_id_instr,          NOP);
        check("async_rst if_id_pc",    if_id_pc,             32'd0);
        @(negedge clk);
        rst_n = 1;
        imem_rvalid = 1; imem_rdata = 32'h1234_5678;   // stray response
        @(negedge clk);
        imem_rvalid = 0;
        check("stray imem_req",    {31'd0, imem_req},    32'd1);
        check("stray imem_addr",   imem_addr,            32'd0);
        check("stray if_id_valid", {31'd0, if_id_valid}, 32'd0);
        check("stray if_id_instr", if_id_instr,          NOP);
        @(negedge clk);
        check("stray2 if_id_valid", {31'd0, if_id_valid}, 32'd0);

        // Randomized run against the fetch-stream model.
        rst_n = 0;
        drive_idle();
        @(negedge clk);
        rst_n = 1;
        m_valid = 0; m_instr = NOP; m_pc = 0; m_next = 0;
        pend = 0; pend_kill = 0; pend_addr = 0; rdy = 0; rdy_addr = 0;
        mem_busy = 0; mem_wait = 0; mem_addr = 0; quiet = 0;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            logic g;
            check("rand if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
            check("rand if_id_instr", if_id_instr, m_instr);
            check("rand if_id_pc",    if_id_pc,    m_pc);
            check("rand addr_align",  {30'd0, imem_addr[1:0]}, 32'd0);
            if (imem_req) begin
                check("rand fetch_addr", imem_addr, m_next);
                check("rand one_outstanding", {31'd0, pend | rdy}, 32'd0);
            end
            quiet = if_id_valid ? 0 : quiet + 1;
            if (quiet > 200) begin
                check("rand progress_watchdog", quiet, 32'd0);
                break;
            end

            stall          = ($urandom % 4) == 0;
            flush          = ($urandom % 12) == 0;
            redirect_valid = ($urandom % 14) == 0;
            redirect_pc    = (($urandom % 4) == 0) ? (32'hFFFF_FFFC | ($urandom % 4)) : $urandom;
            imem_gnt       = $urandom % 3 != 0;
            imem_rvalid    = 0;
            imem_rdata     = $urandom;
            if (mem_busy) begin
                mem_wait--;
                if (mem_wait == 0) begin
                    imem_rvalid = 1;
                    imem_rdata  = mem_word(mem_addr);
                    mem_busy    = 0;
                end
            end
            g = imem_req && imem_gnt;
            if (g) begin
                mem_busy = 1;
                mem_wait = $urandom_range(1, 3);
                mem_addr = imem_addr;
            end

            // Model: response arrival, new grant, consumption, redirect.
            if (imem_rvalid && pend) begin
                if (!pend_kill) begin
                    rdy = 1; rdy_addr = pend_addr;
                end
                pend = 0;
            end
            if (g) begin
                pend = 1; pend_addr = m_next; pend_kill = 0;
            end
            if (rdy && !stall && !redirect_valid) begin
                if (flush) begin
                    m_valid = 0; m_instr = NOP;
                end else begin
                    m_valid = 1; m_instr = mem_word(rdy_addr); m_pc = rdy_addr;
                end
                m_next = rdy_addr + 32'd4;
                rdy = 0;
            end else if (flush || redirect_valid || !stall) begin
                m_valid = 0; m_instr = NOP;
            end
            if (redirect_valid) begin
                if (pend) pend_kill = 1;
                rdy = 0;
                m_next = redirect_pc & 32'hFFFF_FFFC;
            end
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rv32i_if_stage.md
RV32I_IF_STAGE -- requirements
Module: rv32i_if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0): bubble written to IF/ID on flush and reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 stall  input  1  hazard unit; hold IF/ID contents and block fetch advance.
REQ-006 flush  input  1  invalidate IF/ID contents (branch/jump taken in EX).
REQ-007 redirect_valid  input  1  load new PC this cycle.
REQ-008 redirect_pc  input  32  target PC; bits [1:0] ignored and forced to 0.
REQ-009 imem_req  output  1  fetch request to instruction memory.
REQ-010 imem_addr  output  32  fetch byte address, word-aligned.
REQ-011 imem_gnt  input  1  memory accepted the request this cycle.
REQ-012 imem_rvalid  input  1  imem_rdata valid this cycle.
REQ-013 imem_rdata  input  32  fetched instruction word.
REQ-014 if_id_instr  output  32  registered instruction to the decode stage and immediate generator.
REQ-015 if_id_pc  output  32  registered PC of if_id_instr.
REQ-016 if_id_valid  output  1  if_id_instr holds a real instruction.

Function
REQ-017 States: IDLE, REQ, WAIT, HELD; at most one imem request outstanding.
REQ-018 IDLE: imem_req=0; next cycle -> REQ unconditionally.
REQ-019 REQ: imem_req=1, imem_addr=pc; imem_gnt=1 -> WAIT.
REQ-020 WAIT: imem_req=0; imem_rvalid with stall=0 -> load IF/ID {imem_rdata, pc, valid=1}, pc<=pc+4, -> REQ.
REQ-021 WAIT: imem_rvalid with stall=1 -> capture {imem_rdata, pc} into skid register, -> HELD; IF/ID unchanged.
REQ-022 HELD: stall=0 -> load IF/ID from skid, pc<=pc+4, -> REQ; stall=1 -> remain.
REQ-023 Redirect in REQ (granted or not): pc<=redirect_pc, stay in REQ; a same-cycle grant of the old address is treated as in REQ-024.
REQ-024 Redirect in WAIT: pc<=redirect_pc, set kill flag; the pending imem_rvalid is discarded, kill cleared, -> REQ.
REQ-025 Redirect in HELD: discard skid entry, pc<=redirect_pc, -> REQ.
REQ-026 Redirect in IDLE: pc<=redirect_pc, -> REQ.
REQ-027 Redirect and imem_rvalid in the same cycle: response discarded, never enters IF/ID.
REQ-028 flush=1 or redirect_valid=1: next cycle if_id_valid=0, if_id_instr=NOP_INSTR; flush overrides stall and any same-cycle load.
REQ-029 stall=1 without flush: IF/ID registers hold value; stall never suppresses imem_req in REQ.
REQ-030 PC arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-031 Latency: grant in cycle n, rvalid in cycle n+k (k>=1), if_id_valid=1 in cycle n+k+1 absent stall/redirect.
REQ-032 imem_addr[1:0] always 2'b00.

Reset
REQ-033 rst_n=0 asynchronously forces: state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc=0, if_id_valid=0, skid cleared, kill=0.
REQ-034 Reset mid-transaction drops the outstanding request; an imem_rvalid arriving after rst_n rises while in IDLE is ignored.

Verification
REQ-035 Reset release, gnt immediate, rvalid 1 cycle later with 32'h0050_0093 -> imem_addr=0, then if_id_instr=32'h0050_0093, if_id_pc=0, valid=1; next imem_addr=4.
REQ-036 rvalid while stall=1 for 3 cycles -> IF/ID unchanged through stall, loaded with held word on first stall=0 cycle, next fetch at pc+4.
REQ-037 redirect_valid with redirect_pc=32'h0000_0103 during WAIT -> late rvalid discarded, if_id_valid=0 with NOP, next imem_addr=32'h0000_0100.
REQ-038 flush=1 and stall=1 same cycle -> if_id_valid=0, if_id_instr=32'h0000_0013 next cycle.
REQ-039 redirect to 32'hFFFF_FFFC, fetch completes -> if_id_pc=32'hFFFF_FFFC, next imem_addr=32'h0000_0000.
REQ-040 rst_n pulsed low while in WAIT -> all outputs at REQ-033 values immediately; stray rvalid next cycle produces no valid IF/ID entry.
